// File: rtl/coreport_arb.sv
// coreport_arb: two-master Wishbone arbiter in front of a single coreport slave.
// A master owns the slave for the whole of its cyc; contention alternates using
// the most recently granted master, and every grant change passes through IDLE.
// Optional watchdog, enabled by defining COREPORT_ARB_TIMEOUT_EN, terminates a
// strobe the slave never answers with a one-cycle err to the granted master.

module coreport_arb #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,

  // master 0 request / response
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [2:0]  m0_cti_i,
  input  logic [1:0]  m0_bte_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,

  // master 1 request / response
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic [2:0]  m1_cti_i,
  input  logic [1:0]  m1_bte_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,

  // slave side, one-to-one with the coreport Wishbone inputs
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic [2:0]  s_cti_o,
  output logic [1:0]  s_bte_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,

  // one-hot current grant, 2'b00 when idle
  output logic [1:0]  arb_gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t     state_q;
  logic       last_q;       // most recently granted master (0 or 1)
  logic [1:0] gnt_q;

  logic gnt0;
  logic gnt1;
  logic timeout_hit;        // watchdog fires this cycle (always 0 without the watchdog)

  assign gnt0 = (state_q == GNT0);
  assign gnt1 = (state_q == GNT1);

`ifdef COREPORT_ARB_TIMEOUT_EN
  // The counter holds the number of completed unanswered strobe cycles, so it
  // equals TIMEOUT-1 during the TIMEOUT-th waiting cycle; that is the cycle in
  // which the err pulse is issued and the slave strobe is withdrawn.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wd_cnt_q;
  logic       slave_resp;
  logic       granted_stb;

  assign slave_resp  = s_ack_i | s_err_i | s_rty_i;
  assign granted_stb = (gnt0 & m0_cyc_i & m0_stb_i) | (gnt1 & m1_cyc_i & m1_stb_i);
  assign timeout_hit = granted_stb & ~slave_resp & (wd_cnt_q == TO_LAST);

  // Watchdog: cleared while idle (so every grant starts from 0), on any slave
  // response and when it fires; counts cycles of an unanswered granted strobe.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wd_cnt_q <= 8'd0;
    end else if (state_q == IDLE || slave_resp || timeout_hit) begin
      wd_cnt_q <= 8'd0;
    end else if (granted_stb) begin
      wd_cnt_q <= wd_cnt_q + 8'd1;
    end
  end
`else
  // Without the watchdog a hung slave simply holds the grant.
  logic [7:0] unused_timeout;

  assign unused_timeout = 8'(TIMEOUT);
  assign timeout_hit    = 1'b0;
`endif

  // Grant FSM: hold the owner for its whole cyc, alternate on contention,
  // always return through IDLE so different owners never abut on the slave.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
            state_q <= GNT0;
            gnt_q   <= 2'b01;
          end else if (m1_cyc_i) begin
            state_q <= GNT1;
            gnt_q   <= 2'b10;
          end
        end
        GNT0: begin
          if (!m0_cyc_i || timeout_hit) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b0;
          end
        end
        GNT1: begin
          if (!m1_cyc_i || timeout_hit) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
        end
      endcase
    end
  end

  assign arb_gnt_o = gnt_q;

  // Slave request mux, driven straight from the state so a reset or a release
  // removes cyc from the slave without waiting for an edge.
  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    s_adr_o = 32'd0;
    s_dat_o = 32'd0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = 3'd0;
    s_bte_o = 2'd0;
    case (state_q)
      GNT0: begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_we_o  = m0_we_i;
        s_cyc_o = m0_cyc_i & ~timeout_hit;
        s_stb_o = m0_stb_i & ~timeout_hit;
        s_cti_o = m0_cti_i;
        s_bte_o = m0_bte_i;
      end
      GNT1: begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_we_o  = m1_we_i;
        s_cyc_o = m1_cyc_i & ~timeout_hit;
        s_stb_o = m1_stb_i & ~timeout_hit;
        s_cti_o = m1_cti_i;
        s_bte_o = m1_bte_i;
      end
      default: ;
    endcase
  end

  // Response demux: only the granted master sees the slave; the other gets 0s.
  assign m0_dat_o = gnt0 ? s_dat_i : 32'd0;
  assign m0_ack_o = gnt0 & s_ack_i;
  assign m0_err_o = gnt0 & (s_err_i | timeout_hit);
  assign m0_rty_o = gnt0 & s_rty_i;

  assign m1_dat_o = gnt1 ? s_dat_i : 32'd0;
  assign m1_ack_o = gnt1 & s_ack_i;
  assign m1_err_o = gnt1 & (s_err_i | timeout_hit);
  assign m1_rty_o = gnt1 & s_rty_i;

endmodule
